// File: rtl/pwm_timer.sv
// pwm_timer: memory-mapped multi-channel PWM generator for the shared memory bus.
//
// One prescaled up-counter feeds CHANNELS compare outputs. PERIOD and DUTYn are
// shadowed: the running copies (period_active / duty_active) reload only at a
// counter wrap or when the block is enabled, so a pulse is never cut short or
// stretched mid-period. An optional level interrupt reports the wrap flag.
//
// Register map (offset = address_in[5:2]*4), unused bits read 0:
//   0x00 CTRL      RW  [0] enable, [1] irq_en, [8+n] invert channel n
//   0x04 PRESCALE  RW  tick every PRESCALE+1 clocks
//   0x08 PERIOD    RW  shadowed, counter runs 0..PERIOD inclusive
//   0x0C COUNT     RO  current counter value
//   0x10 STATUS    W1C [0] wrap flag
//   0x20+4*n DUTYn RW  shadowed, channel n active while count < DUTYn
//   all other offsets read 0 and ignore writes
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   address_in     bus address, bits [5:2] decoded
//   sel_in         peripheral select from the system address decode
//   read_in        bus read strobe (reads are side-effect free, so unused)
//   read_value_out read data, 0 whenever sel_in is low
//   write_mask_in  byte lane write enables
//   write_value_in write data
//   ready_out      access complete
//   pwm_out        registered PWM waveforms
//   irq_out        registered level wrap interrupt

module pwm_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         address_in,
  input  logic                sel_in,
  input  logic                read_in,
  output logic [31:0]         read_value_out,
  input  logic [3:0]          write_mask_in,
  input  logic [31:0]         write_value_in,
  output logic                ready_out,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq_out
);

  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_PRESCALE = 4'd1;
  localparam logic [3:0] REG_PERIOD   = 4'd2;
  localparam logic [3:0] REG_COUNT    = 4'd3;
  localparam logic [3:0] REG_STATUS   = 4'd4;
  localparam int         DUTY_BASE    = 8;

  // Bus handshake: the access is a single cycle with zero wait states. While
  // sel_in is high ready_out is high in the same cycle, read_value_out carries
  // the addressed register combinationally, and a write (any write_mask_in bit
  // set) commits on the rising clk edge that ends the cycle. With sel_in low
  // the block drives 0 onto the ORed return path and ignores the bus.

  // Programmer-visible registers
  logic                ctrl_enable;
  logic                ctrl_irq_en;
  logic [CHANNELS-1:0] ctrl_inv;
  logic [WIDTH-1:0]    prescale;
  logic [WIDTH-1:0]    period;
  logic [WIDTH-1:0]    duty [CHANNELS];
  logic                status_flag;

  // Running state
  logic [WIDTH-1:0]    pre_cnt;
  logic [WIDTH-1:0]    count;
  logic [WIDTH-1:0]    period_active;
  logic [WIDTH-1:0]    duty_active [CHANNELS];
  logic [CHANNELS-1:0] pwm_q;
  logic                irq_q;

  // Decode and write strobes
  logic [3:0]          reg_idx;
  logic                wr_any;
  logic                wr_ctrl;
  logic                wr_prescale;
  logic                wr_period;
  logic                wr_status;
  logic [CHANNELS-1:0] wr_duty;

  // Byte-lane merged write values
  logic [WIDTH-1:0]    lane_mask;
  logic [WIDTH-1:0]    prescale_wr;
  logic [WIDTH-1:0]    period_wr;
  logic [WIDTH-1:0]    duty_wr [CHANNELS];

  // Timing events
  logic                tick;
  logic                wrap;
  logic                start;
  logic                shadow_load;
  logic                flag_clear;

  logic [31:0]         rdata;
  logic                unused_ok;

  assign reg_idx     = address_in[5:2];
  assign wr_any      = sel_in && (write_mask_in != 4'b0000);
  assign wr_ctrl     = wr_any && (reg_idx == REG_CTRL);
  assign wr_prescale = wr_any && (reg_idx == REG_PRESCALE);
  assign wr_period   = wr_any && (reg_idx == REG_PERIOD);
  assign wr_status   = wr_any && (reg_idx == REG_STATUS);

  always_comb begin
    wr_duty = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_duty[n] = wr_any && (reg_idx == 4'(DUTY_BASE + n));
    end
  end

  // Expand the byte enables to one bit per field bit so an unwritten lane keeps
  // its old contents.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_mask[i] = write_mask_in[i >> 3];
    end
  end

  always_comb begin
    prescale_wr = (prescale & ~lane_mask) | (write_value_in[WIDTH-1:0] & lane_mask);
    period_wr   = (period   & ~lane_mask) | (write_value_in[WIDTH-1:0] & lane_mask);
    for (int n = 0; n < CHANNELS; n++) begin
      duty_wr[n] = (duty[n] & ~lane_mask) | (write_value_in[WIDTH-1:0] & lane_mask);
    end
  end

  // Counters only move while enabled; an enable write takes effect from the
  // following edge, so the edge that enables still sees the counters at 0.
  assign tick        = ctrl_enable && (pre_cnt == prescale);
  assign wrap        = tick && (count == period_active);
  // 0->1 enable loads the shadows so the first period already uses the latest
  // PERIOD/DUTY values. It can never coincide with wrap (wrap needs enable=1).
  assign start       = wr_ctrl && write_mask_in[0] && write_value_in[0] && !ctrl_enable;
  assign shadow_load = wrap || start;
  assign flag_clear  = wr_status && write_mask_in[0] && write_value_in[0];

  // Register file
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_inv    <= '0;
      prescale    <= '0;
      period      <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        duty[n] <= '0;
      end
    end else begin
      if (wr_ctrl && write_mask_in[0]) begin
        ctrl_enable <= write_value_in[0];
        ctrl_irq_en <= write_value_in[1];
      end
      if (wr_ctrl && write_mask_in[1]) begin
        ctrl_inv <= write_value_in[8 +: CHANNELS];
      end
      if (wr_prescale) begin
        prescale <= prescale_wr;
      end
      if (wr_period) begin
        period <= period_wr;
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (wr_duty[n]) begin
          duty[n] <= duty_wr[n];
        end
      end
    end
  end

  // Prescaler and main counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (!ctrl_enable) begin
      pre_cnt <= '0;
      count   <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
      count   <= wrap ? '0 : count + WIDTH'(1);
    end else begin
      pre_cnt <= pre_cnt + WIDTH'(1);
    end
  end

  // Shadow copies used by the compare logic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_active <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        duty_active[n] <= '0;
      end
    end else if (shadow_load) begin
      period_active <= period;
      for (int n = 0; n < CHANNELS; n++) begin
        duty_active[n] <= duty[n];
      end
    end
  end

  // Wrap flag: a wrap on the same edge as a clear wins so no wrap is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_flag <= 1'b0;
    end else if (wrap) begin
      status_flag <= 1'b1;
    end else if (flag_clear) begin
      status_flag <= 1'b0;
    end
  end

  // Registered outputs. A disabled channel parks at its inactive level, which
  // is the invert bit; reset forces 0 regardless of invert.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_q <= '0;
      irq_q <= 1'b0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        pwm_q[n] <= ctrl_enable ? ((count < duty_active[n]) ^ ctrl_inv[n]) : ctrl_inv[n];
      end
      irq_q <= status_flag & ctrl_irq_en;
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_CTRL: begin
        rdata[0]              = ctrl_enable;
        rdata[1]              = ctrl_irq_en;
        rdata[8 +: CHANNELS]  = ctrl_inv;
      end
      REG_PRESCALE: rdata[WIDTH-1:0] = prescale;
      REG_PERIOD:   rdata[WIDTH-1:0] = period;
      REG_COUNT:    rdata[WIDTH-1:0] = count;
      REG_STATUS:   rdata[0]         = status_flag;
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (reg_idx == 4'(DUTY_BASE + n)) begin
            rdata[WIDTH-1:0] = duty[n];
          end
        end
      end
    endcase
  end

  assign read_value_out = sel_in ? rdata : 32'h0;
  assign ready_out      = sel_in;
  assign pwm_out        = pwm_q;
  assign irq_out        = irq_q;

  // Bus bits this peripheral does not decode.
  assign unused_ok = ^{read_in, address_in[31:6], address_in[1:0], write_value_in};

endmodule
